// File: rtl/spi_burst_ram_if.sv
// -----------------------------------------------------------------------------
// spi_burst_ram_if
// Bundles the command/response signals between the SPI slave data path and
// the burst RAM. Signal prefixes are written from the RAM's point of view:
// i_* flow into the RAM, o_* flow out of it.
//   i_rx_valid : command word on i_din is valid this cycle
//   i_din      : {cmd[1:0], payload[DATA_W-1:0]}
//   o_dout     : read data, qualified by o_tx_valid
//   o_tx_valid : one-cycle pulse per matured read
//   o_busy     : post-reset memory clear sweep in progress
//   o_err      : sticky error flag
// -----------------------------------------------------------------------------
interface spi_burst_ram_if #(
  parameter int DATA_W = 8
);
  logic              i_rx_valid;
  logic [DATA_W+1:0] i_din;
  logic [DATA_W-1:0] o_dout;
  logic              o_tx_valid;
  logic              o_busy;
  logic              o_err;

  // Command source side (SPI rx/tx path or testbench)
  modport master (
    output i_rx_valid,
    output i_din,
    input  o_dout,
    input  o_tx_valid,
    input  o_busy,
    input  o_err
  );

  // RAM side
  modport slave (
    input  i_rx_valid,
    input  i_din,
    output o_dout,
    output o_tx_valid,
    output o_busy,
    output o_err
  );
endinterface

// File: rtl/spi_burst_ram.sv
// -----------------------------------------------------------------------------
// spi_burst_ram
// Single-port RAM driven by SPI command words, with separate write/read
// pointers (optional post-increment), configurable read latency, a
// post-reset sequential clear sweep and a sticky error flag.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous, active-low reset
//   bus   : spi_burst_ram_if.slave (rx_valid/din in, dout/tx_valid/busy/err out)
//
// Commands (bus.i_din[DATA_W+1:DATA_W]), decoded only when idle and valid:
//   00 load write pointer, 01 write data, 10 load read pointer, 11 read data.
//
// Parameter constraints: ADDR_W <= DATA_W, MEM_DEPTH <= 2**ADDR_W,
// READ_LAT in {1,2}, AUTO_INC in {0,1}.
// -----------------------------------------------------------------------------
module spi_burst_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int READ_LAT  = 1,
  parameter int AUTO_INC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_burst_ram_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic [ADDR_W-1:0]  w_wr_ptr_nxt;
  logic [ADDR_W-1:0]  w_rd_ptr_nxt;
  logic [ADDR_W-1:0]  w_clr_cnt_nxt;
  logic               r_busy;
  logic               r_err;
  logic               w_set_err;

  logic [DATA_W-1:0]  r_mem [MEM_DEPTH];
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_wdata;

  logic               w_rd_req;
  logic [DATA_W-1:0]  w_rd_data;
  logic               r_s1_valid;
  logic [DATA_W-1:0]  r_s1_data;
  logic               w_mat_valid;
  logic [DATA_W-1:0]  w_mat_data;
  logic               r_tx_valid;
  logic [DATA_W-1:0]  r_dout;

  logic               w_rx_valid;
  logic [1:0]         w_cmd;
  logic [DATA_W-1:0]  w_payload;

  // True when a pointer addresses an implemented word. Compared at 32 bits so
  // that MEM_DEPTH == 2**ADDR_W does not alias to zero.
  function automatic logic f_in_range(input logic [ADDR_W-1:0] p);
    return (32'(p) < 32'(MEM_DEPTH));
  endfunction

  // Post-increment that wraps at MEM_DEPTH-1 rather than at 2**ADDR_W-1.
  function automatic logic [ADDR_W-1:0] f_ptr_inc(input logic [ADDR_W-1:0] p);
    if (p == LAST_IDX) begin
      return '0;
    end else begin
      return p + ADDR_W'(1);
    end
  endfunction

  assign w_rx_valid = bus.i_rx_valid;
  assign w_cmd      = bus.i_din[DATA_W+1:DATA_W];
  assign w_payload  = bus.i_din[DATA_W-1:0];

  // Out-of-range reads return zero instead of touching the array.
  assign w_rd_data = f_in_range(r_rd_ptr) ? r_mem[r_rd_ptr] : '0;

  // Next-state, pointer, memory-port and error decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_ptr_nxt  = r_wr_ptr;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_clr_cnt_nxt = r_clr_cnt;
    w_mem_we      = 1'b0;
    w_mem_addr    = r_clr_cnt;
    w_mem_wdata   = '0;
    w_rd_req      = 1'b0;
    w_set_err     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_cnt;
        w_mem_wdata = '0;
        if (r_clr_cnt == LAST_IDX) begin
          w_state_nxt   = ST_IDLE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        end
        // Any command arriving during the sweep is dropped and flagged.
        if (w_rx_valid) begin
          w_set_err = 1'b1;
        end else begin
          w_set_err = 1'b0;
        end
      end
      ST_IDLE: begin
        if (w_rx_valid) begin
          case (w_cmd)
            2'b00: begin
              w_wr_ptr_nxt = w_payload[ADDR_W-1:0];
            end
            2'b01: begin
              if (f_in_range(r_wr_ptr)) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_wr_ptr;
                w_mem_wdata = w_payload;
              end else begin
                w_set_err = 1'b1;
              end
              if (AUTO_INC == 1) begin
                w_wr_ptr_nxt = f_ptr_inc(r_wr_ptr);
              end else begin
                w_wr_ptr_nxt = r_wr_ptr;
              end
            end
            2'b10: begin
              w_rd_ptr_nxt = w_payload[ADDR_W-1:0];
            end
            2'b11: begin
              // Read always produces a pulse; data is zero when out of range.
              w_rd_req = 1'b1;
              if (f_in_range(r_rd_ptr)) begin
                w_set_err = 1'b0;
              end else begin
                w_set_err = 1'b1;
              end
              if (AUTO_INC == 1) begin
                w_rd_ptr_nxt = f_ptr_inc(r_rd_ptr);
              end else begin
                w_rd_ptr_nxt = r_rd_ptr;
              end
            end
            default: begin
              w_rd_req = 1'b0;
            end
          endcase
        end else begin
          w_rd_req = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // FSM state, pointers, clear counter, busy and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_busy    <= (w_state_nxt == ST_CLEAR);
      r_err     <= r_err | w_set_err;
    end
  end

  // Memory write port; suppressed on reset edges so a reset never corrupts data.
  always_ff @(posedge clk) begin
    if (rst_n && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // First read stage: captures the addressed word at the command edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_req;
      r_s1_data  <= w_rd_req ? w_rd_data : r_s1_data;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_s2_valid;
      logic [DATA_W-1:0] r_s2_data;

      // Extra pipeline stage for the two-cycle latency variant.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_data  <= r_s1_valid ? r_s1_data : r_s2_data;
        end
      end

      assign w_mat_valid = r_s2_valid;
      assign w_mat_data  = r_s2_data;
    end else begin : g_lat1
      assign w_mat_valid = r_s1_valid;
      assign w_mat_data  = r_s1_data;
    end
  endgenerate

  // Output registers: tx_valid pulses per matured read, dout holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_tx_valid <= w_mat_valid;
      r_dout     <= w_mat_valid ? w_mat_data : r_dout;
    end
  end

  assign bus.o_dout     = r_dout;
  assign bus.o_tx_valid = r_tx_valid;
  assign bus.o_busy     = r_busy;
  assign bus.o_err      = r_err;

endmodule

// File: doc/spi_burst_ram.md
Name: spi_burst_ram

Overview:
Parametrised successor to the SPI-slave single-port RAM. It accepts command words from the SPI slave's rx path and returns read data on the tx path. Additions over the previous generation:
- separate write and read pointers with optional auto-increment, for burst transfers
- configurable read latency
- post-reset sequential memory clear, with a busy flag
- sticky error flag for out-of-range and dropped accesses

Parameters:
DATA_W, 8, data word width; the command word is DATA_W+2 bits.
ADDR_W, 8, pointer width; must satisfy ADDR_W <= DATA_W.
MEM_DEPTH, 256, number of words; must satisfy MEM_DEPTH <= 2**ADDR_W.
READ_LAT, 1, read latency in cycles from the sampled read command to tx_valid; legal values 1 or 2.
AUTO_INC, 1, 1 = pointers post-increment after each data access; 0 = pointers hold.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
rx_valid  in  1  din is valid this cycle
din  in  DATA_W+2  [DATA_W+1:DATA_W] = cmd, [DATA_W-1:0] = payload
dout  out  DATA_W  read data, qualified by tx_valid
tx_valid  out  1  one-cycle pulse per read-data command
busy  out  1  clear sweep in progress; commands are not accepted
err  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - dout=0, tx_valid=0, err=0, busy=1.
  - wr_ptr=0, rd_ptr=0, clear counter=0, read pipeline flushed, FSM=CLEAR.
- FSM state CLEAR:
  - Each cycle writes mem[clr_cnt]=0, then increments clr_cnt.
  - Exits to IDLE after the write of clr_cnt=MEM_DEPTH-1. busy drops in the cycle after that write, so busy is high for exactly MEM_DEPTH cycles after reset release.
  - If rst_n is asserted during CLEAR, the sweep restarts from 0.
- FSM state IDLE: busy=0. Commands are decoded only when rx_valid=1.
  - 00: wr_ptr <= payload[ADDR_W-1:0].
  - 01: mem[wr_ptr] <= payload. If AUTO_INC=1, wr_ptr <= wr_ptr+1.
  - 10: rd_ptr <= payload[ADDR_W-1:0].
  - 11: read mem[rd_ptr], payload ignored. If AUTO_INC=1, rd_ptr <= rd_ptr+1.
  - Payload bits above ADDR_W are ignored for pointer loads.
- Pointer wrap: increment from MEM_DEPTH-1 goes to 0, not to 2**ADDR_W-1.
- Out-of-range access, i.e. a data command (01 or 11) with pointer >= MEM_DEPTH:
  - 01: the write is suppressed; err is set.
  - 11: tx_valid still pulses with dout=0; err is set.
  - The pointer still increments, wrapping to 0.
- rx_valid=1 while busy=1: the command is dropped and err is set.
- Read timing:
  - READ_LAT=1: dout/tx_valid update at the edge after the 11 command is sampled.
  - READ_LAT=2: one extra register stage.
  - Back-to-back 11 commands give one tx_valid pulse per cycle, in order, with no bubbles.
  - tx_valid=0 in every cycle without a matured read.
  - dout holds its last value while tx_valid=0.
- Write-then-read: a write at cycle N is visible to a read command sampled at cycle N+1 or later.
- Reset mid-read: in-flight read results are discarded; tx_valid=0 from the reset edge.
- err clears only on reset.

Test Plan:
1. Release reset with MEM_DEPTH=256 -> busy=1 for exactly 256 cycles. A read of any address afterwards returns 0x00.
2. After busy=0: send 00/0x10, 01/0xA5, 01/0x5A, 10/0x10, 11, 11 (AUTO_INC=1, READ_LAT=1) -> two tx_valid pulses on consecutive cycles with dout=0xA5 then 0x5A; err=0.
3. Same sequence with READ_LAT=2 -> the pulses shift one cycle later, same data. With AUTO_INC=0 -> the second write overwrites, and both reads return 0x5A.
4. Wrap and range, with MEM_DEPTH=200, ADDR_W=8:
   - 00/199, 01/0x11, 01/0x22 -> mem[199]=0x11, mem[0]=0x22.
   - 10/0xF0, 11 -> tx_valid with dout=0x00, err=1.
5. rx_valid=1 during the clear sweep -> command ignored, err=1. Assert rst_n=0 at sweep count 100 -> err=0, and busy stays 1 for a full 256 cycles after release.
6. Issue 11 and assert rst_n=0 on the next cycle -> no tx_valid pulse. dout=0 after reset.
